// File: rtl/video_timing_generator.sv
// ----------------------------------------------------------------------------
// video_timing_generator
//
// Raster timing master for composite_video_encoder. Free-running horizontal
// and vertical counters whose geometry follows the latched video standard
// (PAL/SECAM 625/50 family, NTSC 525/60 family). All outputs are registered
// decodes of the counters, one clock behind them, with hpos/vpos carried
// through the same register stage so they always match the flags.
//
// Ports
//   clk             in   1   system clock
//   rst_n           in   1   asynchronous reset, active low
//   video_standard  in   2   0 = PAL, 1 = NTSC, 2 = SECAM (3 treated as PAL)
//   sync            out  1   1 = sync level
//   newframe        out  1   pulse on the first clock of a frame
//   newline         out  1   pulse on the first clock of every line
//   qam_startburst  out  1   burst trigger pulse (PAL/NTSC only)
//   secam_enabled   out  1   SECAM carrier gate
//   active          out  1   pixel data valid
//   hpos            out  11  horizontal position of the flags
//   vpos            out  9   line number of the flags
//   field           out  1   interlace field (0 unless interlace is built in)
//
// Build option
//   VIDEO_TIMING_INTERLACE_EN : interlaced output. field toggles every frame,
//   field 1 carries one extra line and its broad-pulse block is shifted by
//   half a line. Without the macro frames are progressive and field is 0.
// ----------------------------------------------------------------------------
module video_timing_generator #(
    parameter int unsigned LINE_CLKS_PAL     = 1536,
    parameter int unsigned LINE_CLKS_NTSC    = 1525,
    parameter int unsigned LINES_PAL         = 312,
    parameter int unsigned LINES_NTSC        = 262,
    parameter int unsigned HSYNC_CLKS        = 113,
    parameter int unsigned BURST_START_CLKS  = 134,
    parameter int unsigned ACTIVE_START      = 250,
    parameter int unsigned ACTIVE_END        = 1480,
    parameter int unsigned VSYNC_LINES       = 3,
    parameter int unsigned FIRST_ACTIVE_LINE = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  video_standard,
    output logic        sync,
    output logic        newframe,
    output logic        newline,
    output logic        qam_startburst,
    output logic        secam_enabled,
    output logic        active,
    output logic [10:0] hpos,
    output logic [8:0]  vpos,
    output logic        field
);

    typedef enum logic [1:0] {
        STD_PAL   = 2'd0,
        STD_NTSC  = 2'd1,
        STD_SECAM = 2'd2
    } video_standard_e;

    localparam logic [10:0] LINE_PAL_C  = 11'(LINE_CLKS_PAL);
    localparam logic [10:0] LINE_NTSC_C = 11'(LINE_CLKS_NTSC);
    localparam logic [8:0]  LINES_PAL_C  = 9'(LINES_PAL);
    localparam logic [8:0]  LINES_NTSC_C = 9'(LINES_NTSC);
    localparam logic [10:0] HSYNC_C     = 11'(HSYNC_CLKS);
    localparam logic [10:0] BURST_C     = 11'(BURST_START_CLKS);
    localparam logic [10:0] ACT_START_C = 11'(ACTIVE_START);
    localparam logic [10:0] ACT_END_C   = 11'(ACTIVE_END);
    localparam logic [8:0]  VSYNC_C     = 9'(VSYNC_LINES);
    localparam logic [8:0]  FIRST_ACT_C = 9'(FIRST_ACTIVE_LINE);

    logic [10:0]     h;
    logic [8:0]      v;
    video_standard_e std_q;
    video_standard_e std_next;

    logic [10:0] line_len;
    logic [10:0] half;
    logic [8:0]  frame_last;
    logic        h_wrap;
    logic        v_wrap;
    logic        frame_end;
    logic        broad;
    logic        sync_d;
    logic        qam_d;
    logic        secam_d;
    logic        active_d;

`ifdef VIDEO_TIMING_INTERLACE_EN
    logic field_q;
`endif

    always_comb begin
        line_len  = (std_q == STD_NTSC) ? LINE_NTSC_C : LINE_PAL_C;
        half      = line_len >> 1;
`ifdef VIDEO_TIMING_INTERLACE_EN
        frame_last = ((std_q == STD_NTSC) ? LINES_NTSC_C : LINES_PAL_C)
                     - 9'd1 + {8'd0, field_q};
`else
        frame_last = ((std_q == STD_NTSC) ? LINES_NTSC_C : LINES_PAL_C) - 9'd1;
`endif
        h_wrap    = (h == line_len - 11'd1);
        v_wrap    = (v == frame_last);
        frame_end = h_wrap && v_wrap;

        // Code 3 is not a defined standard; fall back to PAL geometry.
        std_next = (video_standard == 2'd3) ? STD_PAL
                                            : video_standard_e'(video_standard);

`ifdef VIDEO_TIMING_INTERLACE_EN
        // Field 1: the broad-pulse block runs from mid line 0 to mid line
        // VSYNC_LINES, i.e. the same length shifted by half a line.
        if (field_q) begin
            broad = ((v == 9'd0) && (h >= half)) ||
                    ((v != 9'd0) && (v < VSYNC_C)) ||
                    ((v == VSYNC_C) && (h < half));
        end else begin
            broad = (v < VSYNC_C);
        end
`else
        broad = (v < VSYNC_C);
`endif

        // Broad pulses: each half line is sync except its last HSYNC clocks.
        if (broad) begin
            sync_d = (h < half - HSYNC_C) ||
                     ((h >= half) && (h < line_len - HSYNC_C));
        end else begin
            sync_d = (h < HSYNC_C);
        end

        qam_d    = (h == BURST_C) && (v >= VSYNC_C) && (std_q != STD_SECAM);
        secam_d  = (std_q == STD_SECAM) && (v >= FIRST_ACT_C) &&
                   (h >= BURST_C) && (h < ACT_END_C);
        active_d = (v >= FIRST_ACT_C) && (h >= ACT_START_C) && (h < ACT_END_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h              <= '0;
            v              <= '0;
            std_q          <= STD_PAL;
            sync           <= 1'b0;
            newframe       <= 1'b0;
            newline        <= 1'b0;
            qam_startburst <= 1'b0;
            secam_enabled  <= 1'b0;
            active         <= 1'b0;
            hpos           <= '0;
            vpos           <= '0;
        end else begin
            h <= h_wrap ? '0 : h + 11'd1;
            if (h_wrap) begin
                v <= v_wrap ? '0 : v + 9'd1;
            end
`ifdef VIDEO_TIMING_INTERLACE_EN
            // The standard may only change at the start of field 0 so a
            // field pair is always of one standard.
            if (frame_end && field_q) begin
                std_q <= std_next;
            end
`else
            if (frame_end) begin
                std_q <= std_next;
            end
`endif
            sync           <= sync_d;
            newframe       <= (h == 11'd0) && (v == 9'd0);
            newline        <= (h == 11'd0);
            qam_startburst <= qam_d;
            secam_enabled  <= secam_d;
            active         <= active_d;
            hpos           <= h;
            vpos           <= v;
        end
    end

`ifdef VIDEO_TIMING_INTERLACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_q <= 1'b0;
            field   <= 1'b0;
        end else begin
            if (frame_end) begin
                field_q <= ~field_q;
            end
            field <= field_q;
        end
    end
`else
    assign field = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_generator.sv
// ----------------------------------------------------------------------------
// tb_video_timing_generator
//
// Directed bench for video_timing_generator, built with a scaled-down raster
// geometry so whole frames fit in a short run. Position-specific flag values
// come from a vector table; multi-cycle behaviour (line/frame lengths, pulse
// widths, mid-frame standard change, mid-line reset) uses hand sequences.
// ----------------------------------------------------------------------------
module tb_video_timing_generator;

    localparam int LP  = 96;   // PAL/SECAM line clocks
    localparam int LN  = 90;   // NTSC line clocks
    localparam int NP  = 20;   // PAL/SECAM lines per frame
    localparam int NN  = 16;   // NTSC lines per frame
    localparam int HS  = 7;
    localparam int BS  = 9;
    localparam int AS  = 15;
    localparam int AE  = 85;
    localparam int VS  = 3;
    localparam int FAL = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  video_standard = 2'd0;
    logic        sync, newframe, newline, qam_startburst, secam_enabled;
    logic        active, field;
    logic [10:0] hpos;
    logic [8:0]  vpos;

    int checks = 0;
    int errors = 0;

    video_timing_generator #(
        .LINE_CLKS_PAL    (LP),
        .LINE_CLKS_NTSC   (LN),
        .LINES_PAL        (NP),
        .LINES_NTSC       (NN),
        .HSYNC_CLKS       (HS),
        .BURST_START_CLKS (BS),
        .ACTIVE_START     (AS),
        .ACTIVE_END       (AE),
        .VSYNC_LINES      (VS),
        .FIRST_ACTIVE_LINE(FAL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .video_standard(video_standard),
        .sync          (sync),
        .newframe      (newframe),
        .newline       (newline),
        .qam_startburst(qam_startburst),
        .secam_enabled (secam_enabled),
        .active        (active),
        .hpos          (hpos),
        .vpos          (vpos),
        .field         (field)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] std;
        int         v;
        int         h;
        bit         s, q, e, a, nl, nf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance at least one clock, then stop at the negedge where the
    // outputs report position (v,h).
    task automatic seek(input int v, input int h);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        while (!found && n < 6000) begin
            @(negedge clk);
            n++;
            if (int'(vpos) == v && int'(hpos) == h) found = 1'b1;
        end
        chk($sformatf("seek_v%0d_h%0d", v, h), int'(found), 1);
    endtask

    // Clocks until the next newline (frame=0) or newframe (frame=1).
    task automatic wait_pulse(input bit frame, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(frame ? newframe : newline) && n < 4000);
    endtask

    task automatic switch_std(input logic [1:0] s);
        int n;
        video_standard = s;
        wait_pulse(1'b1, n);
        wait_pulse(1'b1, n);
    endtask

    task automatic count_line(input int v, input int len,
                              output int cs, output int cq,
                              output int ce, output int ca);
        seek(v, 0);
        cs = 0; cq = 0; ce = 0; ca = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            cs += int'(sync);
            cq += int'(qam_startburst);
            ce += int'(secam_enabled);
            ca += int'(active);
        end
    endtask

    function automatic int all_outs();
        return int'({sync, newframe, newline, qam_startburst, secam_enabled,
                     active, field, hpos, vpos});
    endfunction

    initial begin
        int n, cs, cq, ce, ca, maxv;
        logic [1:0] cur_std;

        //                std    v   h  s  q  e  a nl nf
        vecs.push_back('{2'd0,  0,  0, 1, 0, 0, 0, 1, 1});
        vecs.push_back('{2'd0,  0, 40, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  0, 41, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  0, 48, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  0, 88, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  0, 89, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  1,  0, 1, 0, 0, 0, 1, 0});
        vecs.push_back('{2'd0,  3,  6, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  3,  7, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  3,  9, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  5, 15, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  6, 14, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0,  6, 15, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{2'd0,  6, 84, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{2'd0,  6, 85, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd0, 19, 95, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd1,  0, 37, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd1,  0, 38, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd1,  0, 45, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd1,  0, 82, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd1,  0, 83, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd1,  0, 89, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd1, 10,  6, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd1, 10,  7, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd1, 10,  9, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{2'd1, 10, 15, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{2'd1, 15, 89, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd2,  5,  9, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd2,  6,  9, 0, 0, 1, 0, 0, 0});
        vecs.push_back('{2'd2, 10,  8, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{2'd2, 10,  9, 0, 0, 1, 0, 0, 0});
        vecs.push_back('{2'd2, 10, 84, 0, 0, 1, 1, 0, 0});
        vecs.push_back('{2'd2, 10, 85, 0, 0, 0, 0, 0, 0});

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);

        // Release: pulses on the first clock, then line and frame lengths
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_newframe", int'(newframe), 1);
        chk("first_newline", int'(newline), 1);
        wait_pulse(1'b0, n);
        chk("pal_line_len", n, LP);
        wait_pulse(1'b1, n);
        chk("pal_frame_len", n + LP, NP * LP);

        // Vector table
        cur_std = 2'd0;
        foreach (vecs[i]) begin
            if (vecs[i].std != cur_std) begin
                switch_std(vecs[i].std);
                cur_std = vecs[i].std;
            end
            seek(vecs[i].v, vecs[i].h);
            chk($sformatf("vec%0d_sync", i), int'(sync), int'(vecs[i].s));
            chk($sformatf("vec%0d_qam", i), int'(qam_startburst), int'(vecs[i].q));
            chk($sformatf("vec%0d_secam", i), int'(secam_enabled), int'(vecs[i].e));
            chk($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].a));
            chk($sformatf("vec%0d_newline", i), int'(newline), int'(vecs[i].nl));
            chk($sformatf("vec%0d_newframe", i), int'(newframe), int'(vecs[i].nf));
        end

        // SECAM: carrier gate width, no burst, gate off before active lines
        count_line(10, LP, cs, cq, ce, ca);
        chk("secam_l10_gate_clks", ce, AE - BS);
        chk("secam_l10_burst_cnt", cq, 0);
        chk("secam_l10_active_clks", ca, AE - AS);
        count_line(5, LP, cs, cq, ce, ca);
        chk("secam_l5_gate_clks", ce, 0);

        // NTSC: hsync width and single burst pulse
        switch_std(2'd1);
        count_line(10, LN, cs, cq, ce, ca);
        chk("ntsc_l10_sync_clks", cs, HS);
        chk("ntsc_l10_burst_cnt", cq, 1);

        // PAL line 0: two broad pulses
        switch_std(2'd0);
        count_line(0, LP, cs, cq, ce, ca);
        chk("pal_l0_sync_clks", cs, 2 * (LP / 2 - HS));

        // Mid-frame PAL->NTSC: finish the PAL frame, then NTSC geometry
        seek(10, 0);
        video_standard = 2'd1;
        wait_pulse(1'b0, n);
        chk("midchg_line_len", n, LP);
        n = 0;
        maxv = 0;
        while (!newframe && n < 4000) begin
            @(negedge clk);
            n++;
            if (!newframe && int'(vpos) > maxv) maxv = int'(vpos);
        end
        chk("midchg_last_pal_line", maxv, NP - 1);
        wait_pulse(1'b1, n);
        chk("midchg_ntsc_frame_len", n, NN * LN);
        wait_pulse(1'b0, n);
        chk("midchg_ntsc_line_len", n, LN);

        // Reset mid-line
        seek(15, 40);
        rst_n = 1'b0;
        #1 chk("midrst_immediate", all_outs(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_hold%0d", i), all_outs(), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_newframe", int'(newframe), 1);
        n = 0;
        while (!active && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_first_active_v", int'(vpos), FAL);
        chk("midrst_first_active_h", int'(hpos), AS);
        chk("midrst_first_active_clks", n, FAL * LP + AS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
